// File: rtl/dm_icache.sv
// Direct-mapped, read-only instruction cache with a line-refill memory port.
// Optional hit/miss statistics counters are enabled by defining DM_ICACHE_STATS_EN.
`timescale 1ns/1ps

module dm_icache #(
   parameter int IDX_W = 6,
   parameter int WRD_W = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req_valid,
   output logic        cpu_req_ready,
   input  logic [31:0] cpu_addr,
   output logic        cpu_rsp_valid,
   output logic [31:0] cpu_rsp_data,
   input  logic        flush,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data
`ifdef DM_ICACHE_STATS_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);

   localparam int TAG_W  = 30 - IDX_W - WRD_W;
   localparam int NLINES = 1 << IDX_W;
   localparam int NWORDS = 1 << (IDX_W + WRD_W);

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      REFILL_REQ,
      REFILL_DATA,
      RESPOND
   } state_t;

   state_t              state_q, state_d;
   logic [31:2]         addr_q, addr_d;
   logic [WRD_W-1:0]    beat_q, beat_d;
   logic                flush_pend_q, flush_pend_d;
   logic [NLINES-1:0]   valid_q, valid_d;
   logic                live_q;

   logic [TAG_W-1:0]    tag_mem  [NLINES];
   logic [31:0]         data_mem [NWORDS];

   logic [IDX_W-1:0]    addr_idx;
   logic [WRD_W-1:0]    addr_wrd;
   logic [TAG_W-1:0]    addr_tag;
   logic                hit;
   logic                last_beat;
   logic [31:0]         rd_word;

   // The byte offset never selects anything in a word-wide cache.
   logic unused_byte_bits;
   assign unused_byte_bits = ^cpu_addr[1:0];

   assign addr_idx  = addr_q[IDX_W+WRD_W+1 -: IDX_W];
   assign addr_wrd  = addr_q[WRD_W+1 -: WRD_W];
   assign addr_tag  = addr_q[31 -: TAG_W];
   assign hit       = valid_q[addr_idx] && (tag_mem[addr_idx] == addr_tag);
   assign last_beat = (beat_q == '1);
   assign rd_word   = data_mem[{addr_idx, addr_wrd}];

   // live_q keeps ready low until the first edge after reset release.
   assign cpu_req_ready = live_q && (state_q == IDLE) && !flush_pend_q && !flush;
   assign mem_req_addr  = {addr_q[31:WRD_W+2], {(WRD_W+2){1'b0}}};
   assign cpu_rsp_data  = cpu_rsp_valid ? rd_word : 32'd0;

   always_comb begin
      // NOTE: every output and next-state value gets a default first so no path infers a latch.
      state_d       = state_q;
      addr_d        = addr_q;
      beat_d        = beat_q;
      flush_pend_d  = flush_pend_q;
      valid_d       = valid_q;
      cpu_rsp_valid = 1'b0;
      mem_req_valid = 1'b0;

      if (state_q != IDLE && flush) flush_pend_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (flush || flush_pend_q) begin
               valid_d      = '0;
               flush_pend_d = 1'b0;
            end else if (cpu_req_valid && cpu_req_ready) begin
               addr_d  = cpu_addr[31:2];
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit) begin
               cpu_rsp_valid = 1'b1;
               state_d       = IDLE;
            end else begin
               state_d = REFILL_REQ;
            end
         end
         REFILL_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_d = REFILL_DATA;
         end
         REFILL_DATA: begin
            if (mem_rsp_valid) begin
               beat_d = beat_q + 1'b1;
               if (last_beat) begin
                  valid_d[addr_idx] = 1'b1;
                  state_d           = RESPOND;
               end
            end
         end
         RESPOND: begin
            cpu_rsp_valid = 1'b1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state_q      <= IDLE;
         addr_q       <= '0;
         beat_q       <= '0;
         flush_pend_q <= 1'b0;
         valid_q      <= '0;
         live_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         beat_q       <= beat_d;
         flush_pend_q <= flush_pend_d;
         valid_q      <= valid_d;
         live_q       <= 1'b1;
      end
   end

   // NOTE: tag and data arrays are not reset; the valid bits alone decide whether a line can hit.
   always_ff @(posedge clk) begin
      if (state_q == REFILL_DATA && mem_rsp_valid) begin
         data_mem[{addr_idx, beat_q}] <= mem_rsp_data;
         if (last_beat) tag_mem[addr_idx] <= addr_tag;
      end
   end

`ifdef DM_ICACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   // Counters survive flush and saturate instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (state_q == LOOKUP) begin
         if (hit && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 32'd1;
         if (!hit && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dm_icache.sv
// Randomised self-checking bench for dm_icache: a line-level cache model predicts
// hit/miss, response cycle and data; one compare process checks every cycle.
`timescale 1ns/1ps

module tb_dm_icache;

   localparam int IDX_W  = 6;
   localparam int WRD_W  = 2;
   localparam int NLINES = 64;
   localparam int NBEATS = 4;
   localparam int LINE_B = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req_valid = 1'b0;
   logic        cpu_req_ready;
   logic [31:0] cpu_addr = '0;
   logic        cpu_rsp_valid;
   logic [31:0] cpu_rsp_data;
   logic        flush = 1'b0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data = '0;
`ifdef DM_ICACHE_STATS_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   dm_icache #(.IDX_W(IDX_W), .WRD_W(WRD_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cpu_req_valid (cpu_req_valid),
      .cpu_req_ready (cpu_req_ready),
      .cpu_addr      (cpu_addr),
      .cpu_rsp_valid (cpu_rsp_valid),
      .cpu_rsp_data  (cpu_rsp_data),
      .flush         (flush),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data)
`ifdef DM_ICACHE_STATS_EN
      ,
      .hit_cnt       (hit_cnt),
      .miss_cnt      (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic        exp_mem_req = 1'b0;
   logic [31:0] exp_mem_addr = '0;

   int  n_pass = 0;
   int  n_total = 0;
   bit  mvalid[NLINES];
   int  mtag[NLINES];
   int  mhit = 0;
   int  mmiss = 0;
   int  refill_cnt = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[31:2], 2'b00} ^ 32'hDEAD_BEEF;
   endfunction

   function automatic int line_of(input logic [31:0] a);
      return int'((a / LINE_B) % NLINES);
   endfunction

   function automatic int tag_of(input logic [31:0] a);
      return int'(a / (LINE_B * NLINES));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < NLINES; i++) mvalid[i] = 1'b0;
   endtask

   // Per-cycle comparison of DUT outputs against the model's expectations.
   always @(negedge clk) begin
      bit ev;
      ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      check("rsp_valid", 32'(cpu_rsp_valid), 32'(ev));
      if (ev) begin
         check("rsp_data", cpu_rsp_data, exp_q[0].data);
         void'(exp_q.pop_front());
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         void'(exp_q.pop_front());
      end
      check("mem_req_valid", 32'(mem_req_valid), 32'(exp_mem_req));
      if (exp_mem_req) check("mem_req_addr", mem_req_addr, exp_mem_addr);
   end

   task automatic do_abort();
      mem_rsp_valid = 1'b0;
      rst_n         = 1'b0;
      exp_q.delete();
      exp_mem_req   = 1'b0;
      clear_model();
      mhit  = 0;
      mmiss = 0;
      #1;
      check("abort_rst_ready", 32'(cpu_req_ready), 32'd0);
      check("abort_rst_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
      check("abort_rst_rsp_data", cpu_rsp_data, 32'd0);
      check("abort_rst_mem_req", 32'(mem_req_valid), 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      check("abort_ready_before_edge", 32'(cpu_req_ready), 32'd0);
      tick();
      check("abort_ready_after_edge", 32'(cpu_req_ready), 32'd1);
   endtask

   task automatic do_read(input logic [31:0] addr, input int w, input int gap,
                          input bit flush_mid, input int abort_beat,
                          output bit refilled, output logic [31:0] data,
                          output int lat, output int hs, output logic [31:0] maddr);
      int          line, tag, budget;
      bit          hit;
      logic [31:0] base;
      refilled = 1'b0;
      data     = '0;
      lat      = 0;
      maddr    = '0;
      cpu_addr      = addr;
      cpu_req_valid = 1'b1;
      budget        = 0;
      #1;
      while (!cpu_req_ready && budget < 50) begin
         mem_rsp_valid = 1'($urandom);
         mem_rsp_data  = $urandom;
         tick();
         budget++;
      end
      hs = cyc;
      if (budget >= 50) begin
         check("req_ready_timeout", 32'(cpu_req_ready), 32'd1);
         cpu_req_valid = 1'b0;
         return;
      end
      line = line_of(addr);
      tag  = tag_of(addr);
      base = (addr / LINE_B) * LINE_B;
      hit  = mvalid[line] && (mtag[line] == tag);
      if (hit) begin
         exp_q.push_back('{hs + 1, mem_word(addr)});
         mhit++;
      end else begin
         exp_q.push_back('{hs + 3 + w + NBEATS + (NBEATS - 1) * gap, mem_word(addr)});
         mmiss++;
      end
      tick();
      cpu_req_valid = 1'b0;
      mem_rsp_valid = 1'($urandom);
      mem_rsp_data  = $urandom;
      if (hit) begin
         data = cpu_rsp_data;
         lat  = cyc - hs;
         tick();
         mem_rsp_valid = 1'b0;
         return;
      end
      tick();
      exp_mem_req   = 1'b1;
      exp_mem_addr  = base;
      maddr         = mem_req_addr;
      mem_rsp_valid = 1'($urandom);
      for (int i = 0; i < w; i++) begin
         mem_req_ready = 1'b0;
         tick();
         mem_rsp_valid = 1'($urandom);
         mem_rsp_data  = $urandom;
      end
      mem_req_ready = 1'b1;
      refill_cnt++;
      tick();
      mem_req_ready = 1'b0;
      exp_mem_req   = 1'b0;
      refilled      = 1'b1;
      for (int k = 0; k < NBEATS; k++) begin
         if (k == abort_beat) begin
            do_abort();
            return;
         end
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = mem_word(base + 32'(4 * k));
         flush         = flush_mid && (k == 1);
         tick();
         flush         = 1'b0;
         mem_rsp_valid = 1'b0;
         mem_rsp_data  = $urandom;
         if (k < NBEATS - 1) repeat (gap) tick();
      end
      data = cpu_rsp_data;
      lat  = cyc - hs;
      mvalid[line] = 1'b1;
      mtag[line]   = tag;
      if (flush_mid) clear_model();
   endtask

   task automatic idle_flush();
      tick();
      flush         = 1'b1;
      cpu_req_valid = 1'b1;
      cpu_addr      = $urandom;
      #1;
      check("flush_blocks_ready", 32'(cpu_req_ready), 32'd0);
      tick();
      flush         = 1'b0;
      cpu_req_valid = 1'b0;
      clear_model();
      #1;
      check("ready_after_flush", 32'(cpu_req_ready), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          r;
      logic [31:0] d, ma, a;
      int          l, h, h1, rc0, w, g, ab;
      bit          fm;

      clear_model();
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_ready", 32'(cpu_req_ready), 32'd0);
      check("rst_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
      check("rst_rsp_data", cpu_rsp_data, 32'd0);
      check("rst_mem_req", 32'(mem_req_valid), 32'd0);
      rst_n = 1'b1;
      #1;
      check("ready_before_first_edge", 32'(cpu_req_ready), 32'd0);
      tick();
      check("ready_after_release", 32'(cpu_req_ready), 32'd1);

      // Cold miss then hits within the same line
      do_read(32'h0000_1008, 0, 0, 1'b0, -1, r, d, l, h, ma);
      check("cold_refilled", 32'(r), 32'd1);
      check("cold_mem_addr", ma, 32'h0000_1000);
      check("cold_data_A2", d, 32'hDEAD_AEE7);
      check("cold_latency", 32'(l), 32'd7);
      do_read(32'h0000_100C, 0, 0, 1'b0, -1, r, d, l, h, ma);
      check("hit_no_refill", 32'(r), 32'd0);
      check("hit_data_A3", d, 32'hDEAD_AEE3);
      check("hit_latency", 32'(l), 32'd1);
      do_read(32'h0000_1000, 0, 0, 1'b0, -1, r, d, l, h1, ma);
      do_read(32'h0000_1004, 0, 0, 1'b0, -1, r, d, l, h, ma);
      check("hit_throughput", 32'(h - h1), 32'd2);
`ifdef DM_ICACHE_STATS_EN
      check("stats_hit_cnt", hit_cnt, 32'd3);
      check("stats_miss_cnt", miss_cnt, 32'd1);
`endif

      // Asynchronous reset pulse away from any clock edge
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      clear_model();
      mhit  = 0;
      mmiss = 0;
      #1;
      check("pulse_ready", 32'(cpu_req_ready), 32'd0);
`ifdef DM_ICACHE_STATS_EN
      check("pulse_hit_cnt", hit_cnt, 32'd0);
      check("pulse_miss_cnt", miss_cnt, 32'd0);
`endif
      #1;
      rst_n = 1'b1;
      tick();

      // Conflict: same index, alternating tags
      rc0 = refill_cnt;
      do_read(32'h0000_1000, 0, 0, 1'b0, -1, r, d, l, h, ma);
      check("conflict1_data", d, 32'hDEAD_AEEF);
      do_read(32'h0000_2000, 1, 0, 1'b0, -1, r, d, l, h, ma);
      check("conflict2_data", d, 32'hDEAD_9EEF);
      do_read(32'h0000_1000, 0, 1, 1'b0, -1, r, d, l, h, ma);
      check("conflict3_refilled", 32'(r), 32'd1);
      check("conflict_refills", 32'(refill_cnt - rc0), 32'd3);

      // Backpressure on request and gapped beats
      do_read(32'h0000_4008, 5, 2, 1'b0, -1, r, d, l, h, ma);
      check("bp_data", d, 32'hDEAD_FEE7);
      check("bp_latency", 32'(l), 32'd18);

      // Flush in IDLE, then flush during a refill of 0x1000
      idle_flush();
      do_read(32'h0000_1000, 0, 0, 1'b1, -1, r, d, l, h, ma);
      check("flush_mid_refilled", 32'(r), 32'd1);
      check("flush_mid_data", d, 32'hDEAD_AEEF);
      do_read(32'h0000_1000, 0, 0, 1'b0, -1, r, d, l, h, ma);
      check("after_flush_miss", 32'(r), 32'd1);

      // Reset in the middle of a refill
      do_read(32'h0000_5000, 1, 1, 1'b0, 2, r, d, l, h, ma);
      do_read(32'h0000_5000, 0, 0, 1'b0, -1, r, d, l, h, ma);
      check("after_abort_miss", 32'(r), 32'd1);

      // Randomised traffic over a small address pool to mix hits, misses and conflicts
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 7) == 0) a = $urandom;
         else a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4)
                  | 32'($urandom_range(0, 15));
         w  = $urandom_range(0, 3);
         g  = $urandom_range(0, 2);
         fm = ($urandom_range(0, 19) == 0);
         ab = ($urandom_range(0, 29) == 0) ? $urandom_range(1, 3) : -1;
         do_read(a, w, g, fm, ab, r, d, l, h, ma);
         if ($urandom_range(0, 14) == 0) idle_flush();
      end
`ifdef DM_ICACHE_STATS_EN
      check("final_hit_cnt", hit_cnt, 32'(mhit));
      check("final_miss_cnt", miss_cnt, 32'(mmiss));
`endif
      repeat (3) tick();
      check("no_missing_responses", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
